// File: rtl/ysyx_25040129_axi_sram_slave.sv
// AXI4 subordinate SRAM model: single-beat writes, single/multi-beat reads, one transaction at a time.
// Define YSYX_25040129_SRAM_DELAY_EN to stretch each delay state to LATENCY cycles.
module ysyx_25040129_axi_sram_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LATENCY     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  input  logic [2:0]  arsize,
  input  logic [7:0]  arlen,
  input  logic [1:0]  arburst,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  output logic        rlast,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int unsigned IdxW     = $clog2(DEPTH_WORDS);
  localparam logic [31:0] ByteSpan = 32'(DEPTH_WORDS) << 2;

  typedef enum logic [2:0] {
    StIdle, StWCollect, StWDelay, StWResp, StRDelay, StRData
  } state_e;

  state_e state_q, state_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic            init_q;
  logic            aw_got_q, w_got_q;
  logic [31:0]     aw_addr_q, w_data_q;
  logic [3:0]      w_strb_q;
  logic [31:0]     r_addr_q;
  logic [2:0]      r_size_q;
  logic [1:0]      r_burst_q;
  logic [7:0]      r_cnt_q;
  logic            rvalid_q, rlast_q, bvalid_q;
  logic [31:0]     rdata_q;
  logic [1:0]      rresp_q, bresp_q;

  logic            ready_en;
  logic            aw_hs, w_hs, ar_hs;
  logic            have_aw, have_w;
  logic            in_delay, delay_done, delay_first;
  logic            load_beat, r_hs, commit;
  logic [31:0]     r_off, aw_off;
  logic            r_in_range, aw_in_range, beat_ok;
  logic [IdxW-1:0] r_idx, aw_idx;

  // Readies stay low during reset and for the first cycle after it.
  assign ready_en = !rst && !init_q;

  assign r_off       = r_addr_q - BASE_ADDR;
  assign aw_off      = aw_addr_q - BASE_ADDR;
  assign r_in_range  = r_off < ByteSpan;
  assign aw_in_range = aw_off < ByteSpan;
  assign r_idx       = r_off[IdxW+1:2];
  assign aw_idx      = aw_off[IdxW+1:2];
  // WRAP and reserved burst types still run the beat count but report SLVERR.
  assign beat_ok     = r_in_range && !r_burst_q[1];

  assign in_delay = (state_q == StWDelay) || (state_q == StRDelay);

`ifdef YSYX_25040129_SRAM_DELAY_EN
  localparam int unsigned DelayCycles = (LATENCY == 0) ? 1 : LATENCY;
  logic [31:0] dly_q;

  assign delay_done  = (dly_q == 32'(DelayCycles - 1));
  assign delay_first = (dly_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      dly_q <= '0;
    end else if (in_delay && !delay_done) begin
      dly_q <= dly_q + 32'd1;
    end else begin
      dly_q <= '0;
    end
  end
`else
  logic unused_latency;
  assign unused_latency = ^LATENCY;
  assign delay_done     = 1'b1;
  assign delay_first    = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    awready = 1'b0;
    wready  = 1'b0;
    arready = 1'b0;
    aw_hs   = 1'b0;
    w_hs    = 1'b0;
    ar_hs   = 1'b0;
    have_aw = 1'b0;
    have_w  = 1'b0;
    unique case (state_q)
      StIdle, StWCollect: begin
        awready = ready_en && !aw_got_q;
        wready  = ready_en && !w_got_q;
        if (state_q == StIdle) begin
          arready = ready_en && !awvalid && !wvalid && !aw_got_q && !w_got_q;
        end
        aw_hs   = awvalid && awready;
        w_hs    = wvalid && wready;
        ar_hs   = arvalid && arready;
        have_aw = aw_got_q || aw_hs;
        have_w  = w_got_q || w_hs;
        if (have_aw && have_w) begin
          state_d = StWDelay;
        end else if (have_aw || have_w) begin
          state_d = StWCollect;
        end else if (ar_hs) begin
          state_d = StRDelay;
        end
      end
      StWDelay: begin
        if (delay_done) state_d = StWResp;
      end
      StWResp: begin
        if (bvalid_q && bready) state_d = StIdle;
      end
      StRDelay: begin
        if (delay_done) state_d = StRData;
      end
      StRData: begin
        if (rvalid_q && rready && rlast_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign load_beat = ((state_q == StRDelay) && delay_done) || ((state_q == StRData) && !rvalid_q);
  assign r_hs      = (state_q == StRData) && rvalid_q && rready;
  assign commit    = !rst && (state_q == StWDelay) && delay_first && aw_in_range;

  always_ff @(posedge clk) begin
    if (rst) begin
      init_q    <= 1'b1;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      r_addr_q  <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      r_cnt_q   <= '0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
    end else begin
      init_q <= 1'b0;
      if (aw_hs) begin
        aw_addr_q <= awaddr;
        aw_got_q  <= 1'b1;
      end
      if (w_hs) begin
        w_data_q <= wdata;
        w_strb_q <= wstrb;
        w_got_q  <= 1'b1;
      end
      if (ar_hs) begin
        r_addr_q  <= araddr;
        r_size_q  <= arsize;
        r_burst_q <= arburst;
        r_cnt_q   <= arlen;
      end
      if ((state_q == StWDelay) && delay_done) begin
        bvalid_q <= 1'b1;
        bresp_q  <= aw_in_range ? 2'b00 : 2'b10;
      end
      if ((state_q == StWResp) && bvalid_q && bready) begin
        bvalid_q <= 1'b0;
        aw_got_q <= 1'b0;
        w_got_q  <= 1'b0;
      end
      if (load_beat) begin
        rvalid_q <= 1'b1;
        rdata_q  <= beat_ok ? mem[r_idx] : 32'h0;
        rresp_q  <= beat_ok ? 2'b00 : 2'b10;
        rlast_q  <= (r_cnt_q == 8'd0);
      end
      // Every beat is followed by one idle cycle while the next word is fetched.
      if (r_hs) begin
        rvalid_q <= 1'b0;
        if (!rlast_q) begin
          r_cnt_q <= r_cnt_q - 8'd1;
          if (r_burst_q == 2'b01) begin
            r_addr_q <= r_addr_q + (32'd1 << r_size_q);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (w_strb_q[i]) mem[aw_idx][8*i +: 8] <= w_data_q[8*i +: 8];
      end
    end
  end

  assign rvalid = rvalid_q && !rst;
  assign rlast  = rlast_q && !rst;
  assign rdata  = rst ? 32'h0 : rdata_q;
  assign rresp  = rst ? 2'b00 : rresp_q;
  assign bvalid = bvalid_q && !rst;
  assign bresp  = rst ? 2'b00 : bresp_q;

endmodule
